// File: rtl/fill_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : fill_pkg                                                 |
// | Brief   : Shared types and sizes for the cache line-fill server    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fill_pkg;
    localparam int BURST_LEN = 4;
    localparam int WORD_W    = 16;
    localparam int IDX_W     = $clog2(BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_REPLAY  = 3'd3,
        ST_RELEASE = 3'd4
    } fill_state_e;
endpackage
`default_nettype wire

// File: rtl/cache_fill_server_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : cache_fill_server_if                                     |
// | Brief   : Cache-side fill handshake plus SDRAM read-port signals   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface cache_fill_server_if #(
    parameter int ADDRBITS = 26
);
    import fill_pkg::*;

    logic                  cache_req;
    logic [31:0]           cache_addr;
    logic                  cache_fill;
    logic [WORD_W-1:0]     cache_data;
    logic                  busy;
    logic                  mem_req;
    logic [ADDRBITS-2:0]   mem_addr;
    logic                  mem_ack;
    logic                  mem_rd_valid;
    logic [WORD_W-1:0]     mem_rd_data;
    logic                  err;

    modport slave (
        input  cache_req, cache_addr, mem_ack, mem_rd_valid, mem_rd_data,
        output cache_fill, cache_data, busy, mem_req, mem_addr, err
    );

    modport master (
        output cache_req, cache_addr, mem_ack, mem_rd_valid, mem_rd_data,
        input  cache_fill, cache_data, busy, mem_req, mem_addr, err
    );
endinterface
`default_nettype wire

// File: rtl/fill_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : fill_buffer                                              |
// | Brief   : BURST_LEN x WORD_W register file, registered read port   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fill_buffer
    import fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [WORD_W-1:0] o_rd_data
);
    logic [WORD_W-1:0] r_mem [BURST_LEN];
    logic [WORD_W-1:0] r_rd_data;

    // Storage is deliberately left out of reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/cache_fill_server.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : cache_fill_server                                        |
// | Brief   : Buffers one SDRAM burst and replays it gap-free to cache |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cache_fill_server
    import fill_pkg::*;
#(
    parameter int ADDRBITS = 26,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    cache_fill_server_if.slave bus
);
    localparam int c_wdog_w = $clog2(TIMEOUT + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_max  = c_wdog_w'(TIMEOUT);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]    c_idx_last  = IDX_W'(BURST_LEN - 1);

    fill_state_e          r_state;
    fill_state_e          w_next;
    logic [IDX_W-1:0]     r_wr_idx;
    logic [IDX_W-1:0]     r_rd_idx;
    logic [IDX_W-1:0]     w_rd_sel;
    logic [c_wdog_w-1:0]  r_wdog;
    logic [ADDRBITS-2:0]  r_mem_addr;
    logic                 r_mem_req;
    logic                 r_cache_fill;
    logic                 r_busy;
    logic                 r_err;
    logic                 w_collecting;
    logic                 w_we;
    logic                 w_last_word;
    logic                 w_timeout;
    logic                 w_rd_en;
    logic                 w_accept;
    logic [WORD_W-1:0]    w_rd_data;
    logic                 w_unused;

    assign w_unused = ^{bus.cache_addr[31:ADDRBITS], bus.cache_addr[0]};

    always_comb begin
        w_next       = r_state;
        w_collecting = (r_state == ST_ISSUE) || (r_state == ST_COLLECT);
        w_accept     = (r_state == ST_IDLE) && bus.cache_req;
        w_we         = w_collecting && bus.mem_rd_valid;
        w_last_word  = w_we && (r_wr_idx == c_idx_last);
        // A fourth word landing on the final allowed cycle wins over the timeout.
        w_timeout    = w_collecting && !w_last_word && (r_wdog == c_wdog_last);

        case (r_state)
            ST_IDLE: begin
                if (bus.cache_req) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_last_word || w_timeout) w_next = ST_REPLAY;
                else if (bus.mem_ack)         w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_last_word || w_timeout) w_next = ST_REPLAY;
            end
            ST_REPLAY: begin
                if (r_rd_idx == c_idx_last) w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus.cache_req) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase

        // Read one word ahead so cache_data lines up with the registered cache_fill.
        w_rd_en  = (w_next == ST_REPLAY);
        w_rd_sel = (r_state == ST_REPLAY) ? r_rd_idx + IDX_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_wdog       <= '0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_cache_fill <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_mem_req    <= (w_next == ST_ISSUE);
            r_cache_fill <= (w_next == ST_REPLAY);
            r_busy       <= (w_next != ST_IDLE);
            r_rd_idx     <= w_rd_en ? w_rd_sel : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_mem_addr <= bus.cache_addr[ADDRBITS-1:1];
                r_wdog     <= '0;
                r_wr_idx   <= '0;
            end else begin
                if (w_collecting && (r_wdog != c_wdog_max)) begin
                    r_wdog <= r_wdog + c_wdog_w'(1);
                end
                if (w_we) begin
                    r_wr_idx <= r_wr_idx + IDX_W'(1);
                end
            end
        end
    end

    fill_buffer u_buffer (
        .clk       (clk),
        .rst       (reset),
        .i_we      (w_we),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (bus.mem_rd_data),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_rd_sel),
        .o_rd_data (w_rd_data)
    );

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.cache_fill = r_cache_fill;
    assign bus.cache_data = w_rd_data;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_cache_fill_server.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_cache_fill_server                                     |
// | Brief   : Directed scoreboard bench for cache_fill_server          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cache_fill_server;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   fill_run;
    logic [15:0] exp_q[$];

    cache_fill_server_if #(.ADDRBITS(26)) bus ();

    cache_fill_server #(.ADDRBITS(26), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr);
        bus.cache_req  = 1'b1;
        bus.cache_addr = addr;
        cycle();
        check("mem_req_rise", 32'(bus.mem_req), 32'd1);
        check("busy_rise", 32'(bus.busy), 32'd1);
    endtask

    task automatic strobe(input logic [15:0] d);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = d;
        cycle();
        bus.mem_rd_valid = 1'b0;
    endtask

    // Words are given in arrival order; the replay must reproduce that order.
    task automatic do_burst(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input int ack_dly, input int gap, input bit ack_with_data);
        logic [15:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
        repeat (ack_dly) cycle();
        bus.mem_ack = 1'b1;
        if (ack_with_data) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = w[0];
        end
        cycle();
        bus.mem_ack      = 1'b0;
        bus.mem_rd_valid = 1'b0;
        check("mem_req_drop", 32'(bus.mem_req), 32'd0);
        for (int i = (ack_with_data ? 1 : 0); i < 4; i++) begin
            if (i != 0) repeat (gap) cycle();
            check("no_early_fill", 32'(bus.cache_fill), 32'd0);
            strobe(w[i]);
        end
        check("fill_after_4th", 32'(bus.cache_fill), 32'd1);
        repeat (4) cycle();
        check("release_state", 32'({bus.cache_fill, bus.busy}), 32'b01);
    endtask

    task automatic drop_request();
        bus.cache_req = 1'b0;
        cycle();
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin : monitor
        fill_run = 0;
        forever begin
            @(negedge clk);
            if (bus.cache_fill) begin
                fill_run++;
                if (exp_q.size() == 0) begin
                    check("fill_unexpected", 32'd1, 32'd0);
                end else begin
                    check("cache_data", 32'(bus.cache_data), 32'(exp_q.pop_front()));
                end
            end else if (fill_run != 0) begin
                check("fill_run_len", 32'(fill_run), 32'd4);
                fill_run = 0;
            end
        end
    end

    initial begin : time_guard
        #200000;
        $display("FAIL time_guard: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        bit saw_req;
        n_checks         = 0;
        n_errors         = 0;
        reset            = 1'b1;
        bus.cache_req    = 1'b0;
        bus.cache_addr   = '0;
        bus.mem_ack      = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        repeat (2) cycle();
        check("rst_outputs", 32'({bus.mem_req, bus.cache_fill, bus.busy, bus.err}), 32'd0);
        check("rst_data", 32'(bus.cache_data), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b0;
        cycle();

        // Normal burst, critical word 3
        request(32'h0001_2346);
        check("mem_addr", 32'(bus.mem_addr), 32'h91A3);
        bus.cache_addr = 32'hFFFF_FFFF;
        do_burst(16'hA003, 16'hA000, 16'hA001, 16'hA002, 2, 0, 1'b0);
        check("mem_addr_held", 32'(bus.mem_addr), 32'h91A3);
        drop_request();

        // Gapped return, fourth word on the last allowed watchdog cycle, then held request
        request(32'h0001_2346);
        do_burst(16'hB003, 16'hB000, 16'hB001, 16'hB002, 2, 3, 1'b0);
        check("gap_no_err", 32'(bus.err), 32'd0);
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req || !bus.busy) saw_req = 1'b1;
            cycle();
        end
        check("held_no_rereq", 32'(saw_req), 32'd0);
        drop_request();

        // Ack and first word in the same cycle
        request(32'h0000_0100);
        check("mem_addr_c", 32'(bus.mem_addr), 32'h80);
        do_burst(16'hC111, 16'hC222, 16'hC333, 16'hC444, 1, 1, 1'b1);
        drop_request();

        // Timeout: two words only, slots 2/3 replay the previous burst
        exp_q.push_back(16'hD000);
        exp_q.push_back(16'hD001);
        exp_q.push_back(16'hC333);
        exp_q.push_back(16'hC444);
        request(32'h0000_0200);                 // cycle 1 of mem_req
        cycle();                                // cycle 2
        bus.mem_ack = 1'b1;
        cycle();                                // cycle 3
        bus.mem_ack = 1'b0;
        strobe(16'hD000);                       // cycle 4
        strobe(16'hD001);                       // cycle 5
        repeat (11) cycle();                    // cycle 16
        check("err_not_yet", 32'({bus.err, bus.cache_fill}), 32'b00);
        cycle();                                // cycle 17
        check("err_set", 32'(bus.err), 32'd1);
        check("timeout_fill", 32'({bus.mem_req, bus.cache_fill}), 32'b01);
        repeat (4) cycle();
        bus.mem_rd_valid = 1'b1;                // stray strobe outside collect
        drop_request();
        bus.mem_rd_valid = 1'b0;
        check("err_sticky", 32'(bus.err), 32'd1);

        // Reset mid-collect, late strobes dropped, new request completes
        request(32'h0000_0300);
        bus.mem_ack = 1'b1;
        cycle();
        bus.mem_ack = 1'b0;
        strobe(16'h1111);
        strobe(16'h2222);
        reset         = 1'b1;
        bus.cache_req = 1'b0;
        cycle();
        reset = 1'b0;
        check("rst_mid_outputs", 32'({bus.mem_req, bus.cache_fill, bus.busy, bus.err}), 32'd0);
        check("rst_mid_data", 32'(bus.cache_data), 32'd0);
        check("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
        strobe(16'h3333);
        strobe(16'h4444);
        cycle();
        check("late_ignored", 32'({bus.busy, bus.cache_fill}), 32'b00);
        request(32'h0000_0402);
        check("mem_addr_e", 32'(bus.mem_addr), 32'h201);
        do_burst(16'hE001, 16'hE002, 16'hE003, 16'hE000, 1, 0, 1'b0);
        drop_request();
        check("final_err", 32'(bus.err), 32'd0);

        repeat (3) cycle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
